// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar master-side adapters.
package xbar_pkg;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   localparam int unsigned XBAR_AW = 32;
   localparam int unsigned XBAR_DW = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_RDATA = 2'd2
   } state_t;

endpackage

// File: rtl/xbar_req_fifo.sv
// Request FIFO holding {cmd, addr, wdata}; exposes head and the entry behind it.
module xbar_req_fifo
   import xbar_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = XBAR_AW,
   parameter int unsigned DW    = XBAR_DW
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     push_cmd,
   input  logic [AW-1:0]            push_addr,
   input  logic [DW-1:0]            push_wdata,
   input  logic                     pop,
   output logic                     head_cmd,
   output logic [AW-1:0]            head_addr,
   output logic [DW-1:0]            head_wdata,
   output logic                     next_cmd,
   output logic [AW-1:0]            next_addr,
   output logic [DW-1:0]            next_wdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned EW = 1 + AW + DW;

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] rd_nxt;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_nxt  = rd_ptr + 1'b1;

   assign {head_cmd, head_addr, head_wdata} = mem[rd_ptr];
   assign {next_cmd, next_addr, next_wdata} = mem[rd_nxt];

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {push_cmd, push_addr, push_wdata};
   end

   // Pointers wrap naturally at DEPTH (power of 2); count tracks occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_nxt;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/xbar_master_port.sv
// Master-side crossbar adapter: queues requests, issues them one at a time,
// holds them until ack and returns one in-order response per request.
module xbar_master_port
   import xbar_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = XBAR_AW,
   parameter int unsigned DW    = XBAR_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_cmd,
   input  logic [AW-1:0] in_addr,
   input  logic [DW-1:0] in_wdata,
   output logic          resp_valid,
   output logic          resp_cmd,
   output logic [DW-1:0] resp_rdata,
   output logic          m_req,
   output logic          m_cmd,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic          m_ack,
   input  logic [DW-1:0] m_rdata
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_t        state;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          pop;
   logic          head_cmd;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_wdata;
   logic          next_cmd;
   logic [AW-1:0] next_addr;
   logic [DW-1:0] next_wdata;

   assign in_ready = ~full;
   assign pop      = (state == ST_REQ) & m_ack;

   xbar_req_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (in_valid),
      .push_cmd   (in_cmd),
      .push_addr  (in_addr),
      .push_wdata (in_wdata),
      .pop        (pop),
      .head_cmd   (head_cmd),
      .head_addr  (head_addr),
      .head_wdata (head_wdata),
      .next_cmd   (next_cmd),
      .next_addr  (next_addr),
      .next_wdata (next_wdata),
      .count      (count),
      .full       (full),
      .empty      (empty)
   );

   // Request FSM with registered crossbar and response outputs.
   // On a write ack with more entries queued, the entry behind the head is
   // loaded directly so back-to-back writes issue one per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         m_req      <= 1'b0;
         m_cmd      <= CMD_READ;
         m_addr     <= '0;
         m_wdata    <= '0;
         resp_valid <= 1'b0;
         resp_cmd   <= CMD_READ;
         resp_rdata <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  state   <= ST_REQ;
                  m_req   <= 1'b1;
                  m_cmd   <= head_cmd;
                  m_addr  <= head_addr;
                  m_wdata <= head_wdata;
               end
            end
            ST_REQ: begin
               if (m_ack) begin
                  if (m_cmd == CMD_WRITE) begin
                     resp_valid <= 1'b1;
                     resp_cmd   <= CMD_WRITE;
                     resp_rdata <= '0;
                     if (count > CW'(1)) begin
                        m_cmd   <= next_cmd;
                        m_addr  <= next_addr;
                        m_wdata <= next_wdata;
                     end else begin
                        state <= ST_IDLE;
                        m_req <= 1'b0;
                     end
                  end else begin
                     state <= ST_RDATA;
                     m_req <= 1'b0;
                  end
               end
            end
            ST_RDATA: begin
               resp_valid <= 1'b1;
               resp_cmd   <= CMD_READ;
               resp_rdata <= m_rdata;
               if (!empty) begin
                  state   <= ST_REQ;
                  m_req   <= 1'b1;
                  m_cmd   <= head_cmd;
                  m_addr  <= head_addr;
                  m_wdata <= head_wdata;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               m_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xbar_master_port.sv
// Scoreboard bench for xbar_master_port: a request queue models the FIFO,
// an expected-response queue is filled on ack and drained on resp_valid.
module tb_xbar_master_port;

   localparam int DEPTH = 4;
   localparam int ACK_OFF  = 0;
   localparam int ACK_ON   = 1;
   localparam int ACK_RAND = 2;

   typedef struct packed {
      logic        cmd;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic        cmd;
      logic [31:0] rdata;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_cmd;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic        resp_valid;
   logic        resp_cmd;
   logic [31:0] resp_rdata;
   logic        m_req;
   logic        m_cmd;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_ack = 1'b0;
   logic [31:0] m_rdata = '0;

   int    vectors = 0;
   int    miscompares = 0;
   int    ack_mode = ACK_OFF;
   bit    rdata_fix = 1'b0;
   bit    rd_pending = 1'b0;
   req_t  req_q[$];
   resp_t resp_q[$];

   xbar_master_port #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_cmd     (in_cmd),
      .in_addr    (in_addr),
      .in_wdata   (in_wdata),
      .resp_valid (resp_valid),
      .resp_cmd   (resp_cmd),
      .resp_rdata (resp_rdata),
      .m_req      (m_req),
      .m_cmd      (m_cmd),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .m_ack      (m_ack),
      .m_rdata    (m_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Crossbar slave emulation: ack pattern and read data, changed after each edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ack_mode)
            ACK_ON:   m_ack = 1'b1;
            ACK_RAND: m_ack = 1'($urandom_range(0, 1));
            default:  m_ack = 1'b0;
         endcase
         m_rdata = rdata_fix ? 32'h1234_5678 : $urandom;
      end
   end

   // Monitor / reference model, evaluated mid-cycle for the upcoming edge.
   always @(negedge clk) begin
      if (!rst) begin
         int    occ;
         req_t  e;
         resp_t r;
         if (rd_pending) begin
            resp_q.push_back('{cmd: 1'b0, rdata: m_rdata});
            rd_pending = 1'b0;
         end
         if (resp_valid) begin
            if (resp_q.size() == 0) begin
               check("resp_spurious", 32'(resp_valid), 32'd0);
            end else begin
               r = resp_q.pop_front();
               check("resp_cmd", 32'(resp_cmd), 32'(r.cmd));
               check("resp_rdata", resp_rdata, r.rdata);
            end
         end
         occ = req_q.size();
         check("in_ready", 32'(in_ready), 32'(occ < DEPTH));
         if (m_req) begin
            if (occ == 0) begin
               check("m_req_spurious", 32'(m_req), 32'd0);
            end else begin
               check("m_cmd", 32'(m_cmd), 32'(req_q[0].cmd));
               check("m_addr", m_addr, req_q[0].addr);
               check("m_wdata", m_wdata, req_q[0].wdata);
               if (m_ack) begin
                  e = req_q.pop_front();
                  if (e.cmd) resp_q.push_back('{cmd: 1'b1, rdata: 32'd0});
                  else       rd_pending = 1'b1;
               end
            end
         end
         if (in_valid && occ < DEPTH)
            req_q.push_back('{cmd: in_cmd, addr: in_addr, wdata: in_wdata});
      end
   end

   // Offer one request from a clock-aligned point, hold until accepted.
   task automatic push(input logic c, input logic [31:0] a, input logic [31:0] w);
      bit ok;
      ok = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_cmd   = c;
      in_addr  = a;
      in_wdata = w;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("push_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         #1;
         if (req_q.size() == 0 && resp_q.size() == 0 && !rd_pending) begin
            done = 1'b1;
            break;
         end
      end
      check(name, 32'(done), 32'd1);
   endtask

   initial begin
      int n;
      int first;
      int last;
      bit seen;

      rst      = 1'b1;
      in_valid = 1'b0;
      in_cmd   = 1'b0;
      in_addr  = '0;
      in_wdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_m_req", 32'(m_req), 32'd0);
      check("rst_m_cmd", 32'(m_cmd), 32'd0);
      check("rst_m_addr", m_addr, 32'd0);
      check("rst_m_wdata", m_wdata, 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_cmd", 32'(resp_cmd), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      #2 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Single write, ack held high
      ack_mode = ACK_ON;
      @(negedge clk);
      push(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      @(negedge clk);
      check("w_req_not_yet", 32'(m_req), 32'd0);
      @(negedge clk);
      check("w_req", 32'(m_req), 32'd1);
      check("w_cmd", 32'(m_cmd), 32'd1);
      check("w_addr", m_addr, 32'h0000_0010);
      check("w_wdata", m_wdata, 32'hDEAD_BEEF);
      @(negedge clk);
      check("w_resp_valid", 32'(resp_valid), 32'd1);
      check("w_resp_cmd", 32'(resp_cmd), 32'd1);
      check("w_resp_rdata", resp_rdata, 32'd0);
      check("w_req_dropped", 32'(m_req), 32'd0);
      @(negedge clk);
      check("w_resp_one_pulse", 32'(resp_valid), 32'd0);

      // Single read, ack in the 4th request cycle, fixed read data
      ack_mode  = ACK_OFF;
      rdata_fix = 1'b1;
      @(negedge clk);
      push(1'b0, 32'h8000_0004, 32'h0);
      @(negedge clk);
      check("r_req_not_yet", 32'(m_req), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check("r_req_stable", 32'(m_req), 32'd1);
         check("r_addr_stable", m_addr, 32'h8000_0004);
         if (i == 3) ack_mode = ACK_ON;
         if (i == 4) ack_mode = ACK_OFF;
      end
      @(negedge clk);
      check("r_rdata_cycle_req", 32'(m_req), 32'd0);
      check("r_rdata_cycle_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
      check("r_resp_valid", 32'(resp_valid), 32'd1);
      check("r_resp_cmd", 32'(resp_cmd), 32'd0);
      check("r_resp_rdata", resp_rdata, 32'h1234_5678);
      rdata_fix = 1'b0;
      @(negedge clk);
      check("r_resp_one_pulse", 32'(resp_valid), 32'd0);

      // Fill to DEPTH with ack low, then drain back-to-back
      for (int k = 0; k < DEPTH; k++) push(1'b1, $urandom, $urandom);
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_cmd   = 1'b1;
      in_addr  = 32'hBAD0_0000;
      in_wdata = 32'hBAD0_0001;
      repeat (3) begin
         @(negedge clk);
         check("full_reject", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      ack_mode = ACK_ON;
      n = 0;
      first = -1;
      last = -1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            if (first < 0) first = i;
            last = i;
            n++;
         end
      end
      check("drain_count", 32'(n), 32'd4);
      check("drain_back_to_back", 32'(last - first), 32'd3);
      check("drain_in_ready", 32'(in_ready), 32'd1);

      // Mixed W,R,W with ack always high
      push(1'b1, 32'h0000_0100, 32'hA5A5_0001);
      push(1'b0, 32'h8000_0200, 32'h0);
      push(1'b1, 32'h0000_0300, 32'hA5A5_0003);
      wait_drain("mixed_drain");

      // Reset while a request is outstanding with a second one queued
      ack_mode = ACK_OFF;
      @(negedge clk);
      push(1'b1, 32'h0000_0400, 32'h1111_1111);
      push(1'b1, 32'h0000_0500, 32'h2222_2222);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (m_req) begin
            seen = 1'b1;
            break;
         end
      end
      check("rst_mid_req_seen", 32'(seen), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_m_req", 32'(m_req), 32'd0);
      check("arst_m_cmd", 32'(m_cmd), 32'd0);
      check("arst_m_addr", m_addr, 32'd0);
      check("arst_m_wdata", m_wdata, 32'd0);
      check("arst_resp_valid", 32'(resp_valid), 32'd0);
      check("arst_resp_rdata", resp_rdata, 32'd0);
      req_q.delete();
      resp_q.delete();
      rd_pending = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      ack_mode = ACK_ON;
      repeat (5) begin
         @(negedge clk);
         check("post_rst_no_resp", 32'(resp_valid), 32'd0);
         check("post_rst_no_req", 32'(m_req), 32'd0);
      end
      push(1'b0, 32'h8000_0600, 32'h0);
      @(negedge clk);
      check("pr_req_not_yet", 32'(m_req), 32'd0);
      @(negedge clk);
      check("pr_req", 32'(m_req), 32'd1);
      check("pr_cmd", 32'(m_cmd), 32'd0);
      @(negedge clk);
      check("pr_rdata_cycle_req", 32'(m_req), 32'd0);
      check("pr_rdata_cycle_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
      check("pr_resp_valid", 32'(resp_valid), 32'd1);
      check("pr_resp_cmd", 32'(resp_cmd), 32'd0);

      // Random traffic near full with random ack
      ack_mode = ACK_RAND;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         in_valid = ($urandom_range(0, 3) != 0);
         in_cmd   = 1'($urandom_range(0, 1));
         in_addr  = $urandom;
         in_wdata = $urandom;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ack_mode = ACK_ON;
      wait_drain("random_drain");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
